// File: rtl/axi4lite_dmem_slave_pkg.sv
// Shared AXI4-Lite constants, the byte-merge helper and the FSM debug view for the dmem slave.
package axi4lite_dmem_slave_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam int         AXIL_DATA_W     = 32;
  localparam int         AXIL_STRB_W     = 4;

  // Raw state bits of both channel FSMs, gathered for external checkers.
  typedef struct packed {
    logic [1:0] w_state;
    logic [1:0] r_state;
  } dbg_t;

  function automatic logic [AXIL_DATA_W-1:0] merge_bytes(
    input logic [AXIL_DATA_W-1:0] old_word,
    input logic [AXIL_DATA_W-1:0] new_word,
    input logic [AXIL_STRB_W-1:0] be
  );
    logic [AXIL_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < AXIL_STRB_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_sram_1w1r.sv
// Synchronous word array: one byte-enabled write port, one registered read port (read-before-write).
module axil_sram_1w1r
  import axi4lite_dmem_slave_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [AXIL_DATA_W-1:0] wdata,
  input  logic [AXIL_STRB_W-1:0] be,
  input  logic                   re,
  input  logic [AW-1:0]          raddr,
  output logic [AXIL_DATA_W-1:0] rdata
);

  logic [AXIL_DATA_W-1:0] mem [WORDS];

  // Both ports update on the same edge, so a colliding read captures the pre-write word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= merge_bytes(mem[waddr], wdata, be);
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4lite_dmem_slave.sv
// AXI4-Lite data-memory responder with independent read/write FSMs over one 1W1R word array.
// Optional feature macro: AXIL_SLV_RD_LATENCY_EN adds RD_LAT wait cycles before rvalid.
module axi4lite_dmem_slave
  import axi4lite_dmem_slave_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 4096,
  parameter int RD_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      s_axi_awaddr,
  input  logic [2:0]             s_axi_awprot,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [AXIL_DATA_W-1:0] s_axi_wdata,
  input  logic [AXIL_STRB_W-1:0] s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [ADDR_W-1:0]      s_axi_araddr,
  input  logic [2:0]             s_axi_arprot,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [AXIL_DATA_W-1:0] s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready
);

  localparam int WORDS = MEM_BYTES / 4;
  localparam int WA_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_BYTES);

  typedef enum logic [1:0] {W_IDLE, W_GOT_A, W_GOT_D, W_RESP} w_state_t;
  typedef enum logic [1:0] {
    R_IDLE,
`ifdef AXIL_SLV_RD_LATENCY_EN
    R_WAIT,
`endif
    R_DATA
  } r_state_t;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // a source keeps valid and its payload stable until then, readies are registered.
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  dbg_t     dbg;

  logic                   aw_hs, w_hs, ar_hs, do_write, wr_err, rd_err;
  logic [ADDR_W-1:0]      awaddr_q, wr_addr;
  logic [AXIL_DATA_W-1:0] wdata_q, wr_data, sram_q;
  logic [AXIL_STRB_W-1:0] wstrb_q, wr_strb;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // The second half of a write to arrive is used straight from the bus.
  assign wr_addr = (w_state == W_GOT_A) ? awaddr_q : s_axi_awaddr;
  assign wr_data = (w_state == W_GOT_D) ? wdata_q : s_axi_wdata;
  assign wr_strb = (w_state == W_GOT_D) ? wstrb_q : s_axi_wstrb;
  assign wr_err  = (wr_addr >= LIMIT);
  assign rd_err  = (s_axi_araddr >= LIMIT);

  always_comb begin
    w_next   = w_state;
    do_write = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          do_write = 1'b1;
          w_next   = W_RESP;
        end else if (aw_hs) begin
          w_next = W_GOT_A;
        end else if (w_hs) begin
          w_next = W_GOT_D;
        end
      end
      W_GOT_A: begin
        if (w_hs) begin
          do_write = 1'b1;
          w_next   = W_RESP;
        end
      end
      W_GOT_D: begin
        if (aw_hs) begin
          do_write = 1'b1;
          w_next   = W_RESP;
        end
      end
      W_RESP:  if (s_axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bresp   <= AXI_RESP_OKAY;
    end else begin
      w_state       <= w_next;
      s_axi_awready <= (w_next == W_IDLE) || (w_next == W_GOT_D);
      s_axi_wready  <= (w_next == W_IDLE) || (w_next == W_GOT_A);
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (do_write) s_axi_bresp <= wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    end
  end

  assign s_axi_bvalid = (w_state == W_RESP);

`ifdef AXIL_SLV_RD_LATENCY_EN
  logic [3:0] rd_cnt;
`endif

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
`ifdef AXIL_SLV_RD_LATENCY_EN
          r_next = R_WAIT;
`else
          r_next = R_DATA;
`endif
        end
      end
`ifdef AXIL_SLV_RD_LATENCY_EN
      R_WAIT:  if (rd_cnt == 4'd0) r_next = R_DATA;
`endif
      R_DATA:  if (s_axi_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rresp   <= AXI_RESP_OKAY;
    end else begin
      r_state       <= r_next;
      s_axi_arready <= (r_next == R_IDLE);
      if (ar_hs) s_axi_rresp <= rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    end
  end

`ifdef AXIL_SLV_RD_LATENCY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= 4'd0;
    end else if (ar_hs) begin
      rd_cnt <= 4'(RD_LAT - 1);
    end else if (r_state == R_WAIT && rd_cnt != 4'd0) begin
      rd_cnt <= rd_cnt - 4'd1;
    end
  end
`endif

  assign s_axi_rvalid = (r_state == R_DATA);
  // The array output holds its word until the next AR; errored or idle reads show zero.
  assign s_axi_rdata  = (s_axi_rvalid && s_axi_rresp == AXI_RESP_OKAY) ? sram_q : '0;

  axil_sram_1w1r #(
    .WORDS (WORDS),
    .AW    (WA_W)
  ) u_sram (
    .clk   (clk),
    .we    (do_write && !wr_err),
    .waddr (WA_W'(wr_addr >> 2)),
    .wdata (wr_data),
    .be    (wr_strb),
    .re    (ar_hs),
    .raddr (WA_W'(s_axi_araddr >> 2)),
    .rdata (sram_q)
  );

  assign dbg.w_state = w_state;
  assign dbg.r_state = r_state;

  logic unused_ok;
`ifdef AXIL_SLV_RD_LATENCY_EN
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, dbg};
`else
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, dbg, 4'(RD_LAT)};
`endif

endmodule

// File: tb/tb_axi4lite_dmem_slave.sv
// Directed self-checking bench for axi4lite_dmem_slave with hand-computed expectations.
module tb_axi4lite_dmem_slave;

`ifdef AXIL_SLV_RD_LATENCY_EN
  localparam int RDL      = 3;
  localparam int EXP_RLAT = 4;
`else
  localparam int RDL      = 2;
  localparam int EXP_RLAT = 1;
`endif
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] rdata;

  int          checks = 0;
  int          errors = 0;
  int          n;
  logic [1:0]  resp;
  logic [31:0] exp_q[$];
  logic [31:0] exp_word;

  axi4lite_dmem_slave #(
    .ADDR_W    (32),
    .MEM_BYTES (4096),
    .RD_LAT    (RDL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (awprot),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r);
    logic a_rdy, w_rdy;
    int   k;
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!awvalid && !wvalid) break;
      a_rdy = awready;
      w_rdy = wready;
      step();
      if (a_rdy) awvalid = 1'b0;
      if (w_rdy) wvalid = 1'b0;
    end
    check("wr_accepted", {30'd0, awvalid, wvalid}, 32'd0);
    k = 0;
    while (!bvalid && k < 20) begin
      step();
      k++;
    end
    check("wr_bvalid_seen", {31'd0, bvalid}, 32'd1);
    r      = bresp;
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic wait_rvalid(output int cyc);
    cyc = 1;
    while (!rvalid && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    int   k;
    logic [31:0] e;
    exp_q.push_back(d);
    araddr  = a;
    arvalid = 1'b1;
    k = 0;
    while (!arready && k < 20) begin
      step();
      k++;
    end
    step();
    arvalid = 1'b0;
    wait_rvalid(k);
    check("rd_latency", k, EXP_RLAT);
    e = exp_q.pop_front();
    check("rd_data", rdata, e);
    check("rd_resp", {30'd0, rresp}, {30'd0, r});
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    repeat (3) step();

    // reset values
    check("rst_awready", {31'd0, awready}, 0);
    check("rst_wready", {31'd0, wready}, 0);
    check("rst_arready", {31'd0, arready}, 0);
    check("rst_bvalid", {31'd0, bvalid}, 0);
    check("rst_rvalid", {31'd0, rvalid}, 0);
    check("rst_bresp", {30'd0, bresp}, 0);
    check("rst_rresp", {30'd0, rresp}, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b0;
    check("rel_awready_low", {31'd0, awready}, 0);
    step();
    check("rel_awready", {31'd0, awready}, 1);
    check("rel_wready", {31'd0, wready}, 1);
    check("rel_arready", {31'd0, arready}, 1);

    // 1: AW and W in the same cycle
    awaddr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    step();
    awvalid = 0; wvalid = 0;
    check("t1_bvalid", {31'd0, bvalid}, 1);
    check("t1_bresp", {30'd0, bresp}, OKAY);
    check("t1_awready_busy", {31'd0, awready}, 0);
    check("t1_wready_busy", {31'd0, wready}, 0);
    bready = 1;
    step();
    bready = 0;
    check("t1_bvalid_done", {31'd0, bvalid}, 0);
    check("t1_awready_back", {31'd0, awready}, 1);
    axi_read(32'h10, 32'hDEADBEEF, OKAY);
    axi_read(32'h13, 32'hDEADBEEF, OKAY);

    // 2: W two cycles ahead of AW with partial strobe
    axi_write(32'h14, 32'hAABBCCDD, 4'hF, resp);
    check("t2_prior_resp", {30'd0, resp}, OKAY);
    wdata = 32'h11223344; wstrb = 4'b0011; wvalid = 1;
    step();
    wvalid = 0;
    check("t2_wready_held", {31'd0, wready}, 0);
    check("t2_awready_open", {31'd0, awready}, 1);
    check("t2_no_bvalid", {31'd0, bvalid}, 0);
    step();
    awaddr = 32'h14; awvalid = 1;
    step();
    awvalid = 0;
    check("t2_bvalid", {31'd0, bvalid}, 1);
    bready = 1;
    step();
    bready = 0;
    axi_read(32'h14, 32'hAABB3344, OKAY);

    // 3: out-of-range accesses, empty strobe, last word
    axi_write(32'h0, 32'h01020304, 4'hF, resp);
    check("t3_w0_resp", {30'd0, resp}, OKAY);
    axi_read(32'h1000, 32'h0, SLVERR);
    axi_write(32'h1000, 32'hFFFFFFFF, 4'hF, resp);
    check("t3_werr_resp", {30'd0, resp}, SLVERR);
    axi_read(32'h0, 32'h01020304, OKAY);
    axi_write(32'h0, 32'hFFFFFFFF, 4'h0, resp);
    check("t3_strb0_resp", {30'd0, resp}, OKAY);
    axi_read(32'h0, 32'h01020304, OKAY);
    axi_write(32'hFFC, 32'h5A5A0FF0, 4'hF, resp);
    check("t3_last_resp", {30'd0, resp}, OKAY);
    axi_read(32'hFFC, 32'h5A5A0FF0, OKAY);

    // 4: B stalled for 5 cycles while the next write waits
    awaddr = 32'h30; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    step();
    awaddr = 32'h34; wdata = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      check("t4_bvalid_hold", {31'd0, bvalid}, 1);
      check("t4_bresp_hold", {30'd0, bresp}, OKAY);
      check("t4_awready_low", {31'd0, awready}, 0);
      check("t4_wready_low", {31'd0, wready}, 0);
      step();
    end
    bready = 1;
    step();
    bready = 0;
    check("t4_awready_after_b", {31'd0, awready}, 1);
    step();
    awvalid = 0; wvalid = 0;
    check("t4_second_bvalid", {31'd0, bvalid}, 1);
    bready = 1;
    step();
    bready = 0;
    axi_read(32'h30, 32'hCAFEF00D, OKAY);
    axi_read(32'h34, 32'h0BADF00D, OKAY);

    // 5: same-cycle write and read of one word returns old data
    axi_write(32'h20, 32'h0, 4'hF, resp);
    awaddr = 32'h20; wdata = 32'h55; wstrb = 4'hF; araddr = 32'h20;
    awvalid = 1; wvalid = 1; arvalid = 1;
    exp_q.push_back(32'h0);
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    wait_rvalid(n);
    check("t5_latency", n, EXP_RLAT);
    exp_word = exp_q.pop_front();
    check("t5_old_data", rdata, exp_word);
    check("t5_bvalid", {31'd0, bvalid}, 1);
    bready = 1; rready = 1;
    step();
    bready = 0; rready = 0;
    axi_read(32'h20, 32'h55, OKAY);

    // 6: reset with both responses pending, then a discarded partial write
    awaddr = 32'h40; wdata = 32'h77; wstrb = 4'hF; araddr = 32'h20;
    awvalid = 1; wvalid = 1; arvalid = 1;
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    wait_rvalid(n);
    check("t6_rvalid_pending", {31'd0, rvalid}, 1);
    check("t6_bvalid_pending", {31'd0, bvalid}, 1);
    rst = 1;
    step();
    check("t6_bvalid_drop", {31'd0, bvalid}, 0);
    check("t6_rvalid_drop", {31'd0, rvalid}, 0);
    check("t6_awready_rst", {31'd0, awready}, 0);
    check("t6_arready_rst", {31'd0, arready}, 0);
    check("t6_rdata_rst", rdata, 0);
    rst = 0;
    step();
    check("t6_awready_rel", {31'd0, awready}, 1);
    check("t6_wready_rel", {31'd0, wready}, 1);
    check("t6_arready_rel", {31'd0, arready}, 1);

    wdata = 32'h99; wstrb = 4'hF; wvalid = 1;
    step();
    wvalid = 0;
    rst = 1;
    step();
    rst = 0;
    step();
    awaddr = 32'h20; awvalid = 1;
    step();
    awvalid = 0;
    step();
    check("t6_partial_dropped", {31'd0, bvalid}, 0);
    wdata = 32'h66; wstrb = 4'hF; wvalid = 1;
    step();
    wvalid = 0;
    check("t6_completed_bvalid", {31'd0, bvalid}, 1);
    bready = 1;
    step();
    bready = 0;
    axi_read(32'h20, 32'h66, OKAY);

    check("sb_queue_empty", exp_q.size(), 0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
